ahb_apb_bridge: RTL and testbench
=================================

AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 The module SHALL have an input `hclk`, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have an input `hreset`, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have an input `hwrite`, 1 bit: AHB direction (1 = write).
REQ-004 The module SHALL have an input `hreadyin`, 1 bit: AHB global ready.
REQ-005 The module SHALL have an input `htrans`, 2 bits: AHB transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
REQ-006 The module SHALL have an input `haddr`, 32 bits: AHB address.
REQ-007 The module SHALL have an input `hwdata`, 32 bits: AHB write data, valid in the data phase.
REQ-008 The module SHALL have an input `prdata`, 32 bits: APB read data.
REQ-009 The module SHALL have an output `hreadyout`, 1 bit: bridge ready to the AHB master.
REQ-010 The module SHALL have an output `hrdata`, 32 bits: read data to the AHB master.
REQ-011 The module SHALL have an output `paddr`, 32 bits: APB address.
REQ-012 The module SHALL have an output `pwdata`, 32 bits: APB write data.
REQ-013 The module SHALL have an output `pwrite`, 1 bit: APB direction.
REQ-014 The module SHALL have an output `penable`, 1 bit: APB enable.
REQ-015 The module SHALL have an output `psel`, 3 bits: one-hot APB peripheral select.

Function
REQ-016 A transfer SHALL be valid when hreadyin=1, htrans is 2 or 3, and 0x8000_0000 <= haddr <= 0x8BFF_FFFF.
REQ-017 Decode: SHALL be haddr[31:26]=0x20 -> psel[0]; 0x21 -> psel[1]; 0x22 -> psel[2].
REQ-018 The FSM SHALL have four states: IDLE, W_WAIT, SETUP and ACCESS.
REQ-019 In IDLE, hreadyout SHALL be 1.
REQ-020 In IDLE, a valid read SHALL latch haddr and hwrite and go to SETUP.
REQ-021 In IDLE, a valid write SHALL latch haddr and hwrite and go to W_WAIT.
REQ-022 In IDLE, any other input SHALL keep the FSM in IDLE.
REQ-023 W_WAIT SHALL last one cycle with hreadyout=0, capture hwdata into pwdata, then go to SETUP.
REQ-024 SETUP SHALL last one cycle, driving the decoded psel bit, paddr, pwrite and pwdata with penable=0 and hreadyout=0, then go to ACCESS.
REQ-025 ACCESS SHALL hold psel, paddr, pwrite and pwdata stable with penable=1 and hreadyout=1.
REQ-026 For a read in ACCESS, hrdata SHALL equal prdata; in all other cycles hrdata SHALL be 0.
REQ-027 In ACCESS, a new valid transfer SHALL be accepted exactly as in IDLE (back-to-back, no IDLE gap).
REQ-028 In ACCESS, the absence of a new valid transfer SHALL return the FSM to IDLE.
REQ-029 Latency from address acceptance in cycle N SHALL be: read, penable=1 and hreadyout=1 in N+2; write, penable=1 and hreadyout=1 in N+3.
REQ-030 A valid-type transfer whose address is outside the map SHALL be ignored: no psel, hreadyout stays 1, FSM stays in IDLE.
REQ-031 htrans=1 (BUSY) or htrans=0 (IDLE) SHALL never start a transfer.
REQ-032 hreadyin=0 SHALL block acceptance in IDLE and ACCESS.
REQ-033 psel SHALL be 0 and penable SHALL be 0 in IDLE and W_WAIT.
REQ-034 psel SHALL never have more than one bit set.

Reset
REQ-035 hreset=1 at a clock edge SHALL force IDLE in any state, including mid-SETUP or mid-ACCESS, abandoning the APB transfer.
REQ-036 After reset, hreadyout SHALL be 1, and psel, penable, pwrite, paddr, pwdata and hrdata SHALL all be 0.
REQ-037 Reset SHALL take priority over every simultaneous AHB input.

Configuration
REQ-038 When BRIDGE_PREADY_EN is defined, the module SHALL add an input `pready`, 1 bit.
REQ-039 With BRIDGE_PREADY_EN defined, ACCESS SHALL repeat while pready=0, holding all APB outputs stable with hreadyout=0.
REQ-040 With BRIDGE_PREADY_EN defined, ACCESS SHALL complete per REQ-025 to REQ-028 in the cycle pready=1.
REQ-041 When BRIDGE_PREADY_EN is undefined, the port SHALL be absent and ACCESS SHALL always last exactly one cycle.

Verification
REQ-042 Single write to 0x8000_0001, data 0x80 -> W_WAIT, then SETUP with psel=001, paddr=0x8000_0001, pwdata=0x80, pwrite=1; ACCESS penable=1; hreadyout low for 2 cycles.
REQ-043 Single read from 0x8400_0010 with prdata=0xDEAD_BEEF -> psel=010; hrdata=0xDEAD_BEEF in the ACCESS cycle with hreadyout=1.
REQ-044 Burst of 4 writes (NONSEQ then 3 SEQ) from 0x8800_0001 -> four APB writes to 0x8800_0001..0x8800_0004 on psel=100, back-to-back through ACCESS->W_WAIT, data in order.
REQ-045 NONSEQ to 0x9000_0000, then htrans=1 to 0x8000_0000 -> no psel ever asserted, hreadyout stays 1.
REQ-046 hreset=1 during SETUP of a read -> next cycle IDLE, psel=0, penable=0, hreadyout=1.
REQ-047 (BRIDGE_PREADY_EN) pready held 0 for 3 ACCESS cycles, then 1 -> penable=1 for 4 cycles, hreadyout=0 for 3 cycles then 1.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
// -----------------------------------------------------------------------------
// ahb_apb_bridge
//
// Purpose:
//   Converts AHB-Lite transfers aimed at the peripheral window
//   0x8000_0000 .. 0x8BFF_FFFF into APB transfers on one of three peripheral
//   selects.
//   A read costs a SETUP and an ACCESS cycle. A write needs one extra wait
//   cycle (W_WAIT), because AHB presents write data one cycle after the
//   address.
//   An ACCESS cycle can accept the next AHB transfer directly, so bursts run
//   back-to-back without an IDLE gap.
//
// Ports:
//   hclk       in   clock, all state changes on its rising edge
//   hreset     in   synchronous active-high reset
//   hwrite     in   AHB direction (1 = write)
//   hreadyin   in   AHB global ready; no transfer is accepted while low
//   htrans     in   [1:0] AHB transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   haddr      in   [31:0] AHB address
//   hwdata     in   [31:0] AHB write data (data phase)
//   prdata     in   [31:0] APB read data
//   hreadyout  out  bridge ready to the AHB master
//   hrdata     out  [31:0] read data to AHB (zero except in a read ACCESS)
//   paddr      out  [31:0] APB address
//   pwdata     out  [31:0] APB write data
//   pwrite     out  APB direction
//   penable    out  APB enable (ACCESS phase)
//   psel       out  [2:0] one-hot APB peripheral select
//   pready     in   APB ready (present only with BRIDGE_PREADY_EN)
//
// Configuration:
//   BRIDGE_PREADY_EN  when defined, adds the pready input. ACCESS then
//                     repeats until pready=1, and hreadyout stays low while
//                     it waits. When undefined, ACCESS always lasts one
//                     cycle.
// -----------------------------------------------------------------------------
module ahb_apb_bridge (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        penable,
  output logic [2:0]  psel
`ifdef BRIDGE_PREADY_EN
  ,
  input  logic        pready
`endif
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0]  HTRANS_SEQ    = 2'b11;

  localparam logic [31:0] MAP_LO        = 32'h8000_0000;
  localparam logic [31:0] MAP_HI        = 32'h8BFF_FFFF;

  // Each peripheral owns one 64 MiB region, identified by haddr[31:26].
  localparam logic [5:0]  REGION_PERIPH0 = 6'h20;
  localparam logic [5:0]  REGION_PERIPH1 = 6'h21;
  localparam logic [5:0]  REGION_PERIPH2 = 6'h22;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_W_WAIT = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ACCESS = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;       // address of the transfer in flight
  logic        write_q;      // direction of the transfer in flight
  logic [31:0] wdata_q;      // write data captured during W_WAIT

  logic        addr_in_map;
  logic        trans_active;
  logic        xfer_valid;
  logic        access_done;  // ACCESS completes in this cycle
  logic        accept;       // latch the AHB address phase at this edge

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // Only the three mapped regions produce a select bit, so psel can never
  // have more than one bit set.
  function automatic logic [2:0] region_to_psel(input logic [5:0] region);
    logic [2:0] sel;
    sel = 3'b000;
    case (region)
      REGION_PERIPH0: sel = 3'b001;
      REGION_PERIPH1: sel = 3'b010;
      REGION_PERIPH2: sel = 3'b100;
      default:        sel = 3'b000;
    endcase
    return sel;
  endfunction

  assign addr_in_map  = (haddr >= MAP_LO) && (haddr <= MAP_HI);
  // IDLE and BUSY never start a transfer; only NONSEQ and SEQ do.
  assign trans_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign xfer_valid   = hreadyin && trans_active && addr_in_map;

`ifdef BRIDGE_PREADY_EN
  assign access_done = pready;
`else
  assign access_done = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments.
  // Every register then samples pre-edge values, whatever order the blocks
  // run in.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    hreadyout  = 1'b1;
    penable    = 1'b0;
    psel       = 3'b000;
    hrdata     = 32'h0;

    case (state)
      ST_IDLE: begin
        if (xfer_valid) begin
          accept     = 1'b1;
          state_next = hwrite ? ST_W_WAIT : ST_SETUP;
        end
      end

      // Write data arrives one cycle after the address. Hold the master off
      // for one cycle so the data can be captured.
      ST_W_WAIT: begin
        hreadyout  = 1'b0;
        state_next = ST_SETUP;
      end

      ST_SETUP: begin
        hreadyout  = 1'b0;
        psel       = region_to_psel(addr_q[31:26]);
        state_next = ST_ACCESS;
      end

      ST_ACCESS: begin
        psel      = region_to_psel(addr_q[31:26]);
        penable   = 1'b1;
        hreadyout = access_done;
        if (!write_q) begin
          hrdata = prdata;
        end
        // Once the APB side finishes, this cycle doubles as the AHB address
        // phase of the next transfer. That is what removes the IDLE gap in a
        // burst.
        if (access_done) begin
          if (xfer_valid) begin
            accept     = 1'b1;
            state_next = hwrite ? ST_W_WAIT : ST_SETUP;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // APB address / control / data registers
  // ---------------------------------------------------------------------------
  // These registers change only at the edge that closes an accept or W_WAIT
  // cycle. They therefore stay stable across SETUP and every ACCESS cycle.
  // Reset clears them so that the APB outputs read zero out of reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_q  <= 32'h0;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
    end else begin
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
      end
      if (state == ST_W_WAIT) begin
        wdata_q <= hwdata;
      end
    end
  end

  assign paddr  = addr_q;
  assign pwrite = write_q;
  assign pwdata = wdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_ahb_apb_bridge
//
// Directed bench for ahb_apb_bridge.
//
// Each accepted AHB address phase pushes the APB transfer it should produce
// onto a queue. A negedge monitor pops that entry on every completed ACCESS
// cycle and compares it with the DUT outputs.
//
// Cycle-exact behaviour is checked inline: wait states, SETUP/ACCESS outputs,
// ignored transfers and reset.
//
// Build with +define+BRIDGE_PREADY_EN to include the pready stall sequence.
// -----------------------------------------------------------------------------
module tb_ahb_apb_bridge;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic [2:0]  psel;
`ifdef BRIDGE_PREADY_EN
  logic        pready;
`endif

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;   // pwdata for writes, hrdata for reads
  } apb_exp_t;

  apb_exp_t    sb[$];
  apb_exp_t    mon_e;
  int          n_asserts = 0;
  int          n_fail    = 0;

  logic        prdata_fixed_en;
  logic [31:0] prdata_fixed;

  always #5 hclk = ~hclk;

  ahb_apb_bridge dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hwrite    (hwrite),
    .hreadyin  (hreadyin),
    .htrans    (htrans),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .prdata    (prdata),
    .hreadyout (hreadyout),
    .hrdata    (hrdata),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pwrite    (pwrite),
    .penable   (penable),
    .psel      (psel)
`ifdef BRIDGE_PREADY_EN
    ,
    .pready    (pready)
`endif
  );

  // Peripheral model: read data is a fixed scramble of the APB address,
  // unless a directed step forces a specific value.
  function automatic logic [31:0] periph_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  assign prdata = prdata_fixed_en ? prdata_fixed : periph_data(paddr);

  // Peripheral select is derived from address ranges, not from bit slices.
  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    if (a < 32'h8400_0000)      return 3'b001;
    else if (a < 32'h8800_0000) return 3'b010;
    else                        return 3'b100;
  endfunction

  function automatic apb_exp_t mk_exp(input logic [31:0] a, input logic wr,
                                      input logic [31:0] d);
    apb_exp_t e;
    e.sel   = exp_sel(a);
    e.addr  = a;
    e.write = wr;
    e.data  = d;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic sample();
    @(negedge hclk);
  endtask

  task automatic drive_idle();
    htrans   = 2'b00;
    hwrite   = 1'b0;
    haddr    = 32'h0;
    hreadyin = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: one pop per completed ACCESS cycle.
  // ---------------------------------------------------------------------------
  always @(negedge hclk) begin
    if (hreset === 1'b0 && penable === 1'b1 && hreadyout === 1'b1) begin
      if (sb.size() == 0) begin
        check("apb_unexpected", 32'(penable), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("apb_psel",   32'(psel),   32'(mon_e.sel));
        check("apb_paddr",  paddr,       mon_e.addr);
        check("apb_pwrite", 32'(pwrite), 32'(mon_e.write));
        if (mon_e.write) begin
          check("apb_pwdata",      pwdata, mon_e.data);
          check("hrdata_on_write", hrdata, 32'h0);
        end else begin
          check("apb_hrdata", hrdata, mon_e.data);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Burst master.
  //
  // Models AHB pipelining: the address phase advances, and the previous beat's
  // data phase retires, on every cycle in which hreadyout is high.
  //
  // 'last' returns the cycle index of the final ACCESS, counted from the first
  // address cycle.
  // ---------------------------------------------------------------------------
  task automatic run_burst(input logic [31:0] base, input int n,
                           input logic wr, input logic [31:0] dseed,
                           output int last);
    int   a;
    int   d;
    logic done;
    a    = 0;
    d    = -1;
    done = 1'b0;
    last = -1;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      tick();
      hreadyin = 1'b1;
      hwrite   = wr;
      htrans   = (a >= n) ? 2'b00 : ((a == 0) ? 2'b10 : 2'b11);
      haddr    = (a >= n) ? 32'h0 : base + 32'(a);
      hwdata   = (d >= 0) ? dseed + 32'(d) : 32'h0;
      sample();
      if (hreadyout === 1'b1) begin
        if (a < n) begin
          sb.push_back(mk_exp(base + 32'(a), wr,
                              wr ? dseed + 32'(a) : periph_data(base + 32'(a))));
          d = a;
          a++;
        end else begin
          d = -1;
        end
      end
      if (a >= n && d < 0) begin
        done = 1'b1;
        last = cyc;
      end
    end
    check("burst_done", 32'(done), 32'd1);
  endtask

  logic [1:0]  ign_trans [6] = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
  logic [31:0] ign_addr  [6] = '{32'h9000_0000, 32'h8000_0000, 32'h8000_0000,
                                 32'h8C00_0000, 32'h7FFF_FFFF, 32'h8000_0000};
  logic        ign_ready [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last;

    // ---- Reset, asserted together with a valid write (reset must win) ----
    hreset          = 1'b1;
    hwrite          = 1'b1;
    htrans          = 2'b10;
    haddr           = 32'h8000_0004;
    hreadyin        = 1'b1;
    hwdata          = 32'hFFFF_FFFF;
    prdata_fixed_en = 1'b0;
    prdata_fixed    = 32'h0;
`ifdef BRIDGE_PREADY_EN
    pready          = 1'b1;
`endif
    tick();
    tick();
    sample();
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_psel",      32'(psel),      32'd0);
    check("rst_penable",   32'(penable),   32'd0);
    check("rst_pwrite",    32'(pwrite),    32'd0);
    check("rst_paddr",     paddr,          32'h0);
    check("rst_pwdata",    pwdata,         32'h0);
    check("rst_hrdata",    hrdata,         32'h0);
    tick();
    hreset = 1'b0;
    drive_idle();
    sample();
    check("post_rst_psel", 32'(psel), 32'd0);

    // ---- Single write 0x8000_0001 <- 0x80 ----
    tick();
    hwrite = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h8000_0001;
    sb.push_back(mk_exp(32'h8000_0001, 1'b1, 32'h0000_0080));
    sample();
    check("wr_idle_hready", 32'(hreadyout), 32'd1);
    tick();
    drive_idle();
    hwdata = 32'h0000_0080;
    sample();
    check("wr_wwait_hready",  32'(hreadyout), 32'd0);
    check("wr_wwait_psel",    32'(psel),      32'd0);
    check("wr_wwait_penable", 32'(penable),   32'd0);
    tick();
    hwdata = 32'hBAD0_0000;
    sample();
    check("wr_setup_psel",    32'(psel),      32'b001);
    check("wr_setup_paddr",   paddr,          32'h8000_0001);
    check("wr_setup_pwdata",  pwdata,         32'h0000_0080);
    check("wr_setup_pwrite",  32'(pwrite),    32'd1);
    check("wr_setup_penable", 32'(penable),   32'd0);
    check("wr_setup_hready",  32'(hreadyout), 32'd0);
    tick();
    sample();
    check("wr_access_penable", 32'(penable),   32'd1);
    check("wr_access_hready",  32'(hreadyout), 32'd1);
    check("wr_access_pwdata",  pwdata,         32'h0000_0080);
    tick();
    sample();
    check("wr_done_psel",    32'(psel),      32'd0);
    check("wr_done_penable", 32'(penable),   32'd0);
    check("wr_done_hready",  32'(hreadyout), 32'd1);

    // ---- Single read 0x8400_0010 -> 0xDEAD_BEEF ----
    prdata_fixed_en = 1'b1;
    prdata_fixed    = 32'hDEAD_BEEF;
    tick();
    hwrite = 1'b0;
    htrans = 2'b10;
    haddr  = 32'h8400_0010;
    sb.push_back(mk_exp(32'h8400_0010, 1'b0, 32'hDEAD_BEEF));
    sample();
    check("rd_idle_hready", 32'(hreadyout), 32'd1);
    tick();
    drive_idle();
    sample();
    check("rd_setup_psel",    32'(psel),      32'b010);
    check("rd_setup_penable", 32'(penable),   32'd0);
    check("rd_setup_hready",  32'(hreadyout), 32'd0);
    check("rd_setup_hrdata",  hrdata,         32'h0);
    tick();
    sample();
    check("rd_access_hrdata", hrdata,         32'hDEAD_BEEF);
    check("rd_access_hready", 32'(hreadyout), 32'd1);
    tick();
    sample();
    check("rd_done_hrdata", hrdata,     32'h0);
    check("rd_done_psel",   32'(psel),  32'd0);
    prdata_fixed_en = 1'b0;

    // ---- Bursts: 4 writes, 3 reads across the psel0/psel1 boundary, top address ----
    run_burst(32'h8800_0001, 4, 1'b1, 32'h1000_0000, last);
    check("wr_burst_cycles", 32'(last), 32'd12);
    run_burst(32'h83FF_FFFE, 3, 1'b0, 32'h0, last);
    check("rd_burst_cycles", 32'(last), 32'd6);
    run_burst(32'h8BFF_FFFF, 1, 1'b0, 32'h0, last);
    check("rd_top_cycles", 32'(last), 32'd2);
    tick();
    drive_idle();
    sample();
    check("sb_empty_bursts", 32'(sb.size()), 32'd0);

    // ---- Transfers that must be ignored ----
    for (int i = 0; i < 6; i++) begin
      tick();
      hwrite   = 1'b0;
      htrans   = ign_trans[i];
      haddr    = ign_addr[i];
      hreadyin = ign_ready[i];
      sample();
      check("ign_hready", 32'(hreadyout), 32'd1);
      check("ign_psel",   32'(psel),      32'd0);
    end
    tick();
    drive_idle();
    sample();
    check("ign_after_hready", 32'(hreadyout), 32'd1);
    check("ign_after_psel",   32'(psel),      32'd0);

    // ---- hreadyin=0 in ACCESS blocks the next transfer ----
    tick();
    hwrite = 1'b0;
    htrans = 2'b10;
    haddr  = 32'h8000_0020;
    sb.push_back(mk_exp(32'h8000_0020, 1'b0, periph_data(32'h8000_0020)));
    tick();
    drive_idle();
    tick();
    htrans   = 2'b10;
    haddr    = 32'h8000_0030;
    hreadyin = 1'b0;
    sample();
    check("blk_access_hready", 32'(hreadyout), 32'd1);
    tick();
    drive_idle();
    sample();
    check("blk_next_hready", 32'(hreadyout), 32'd1);
    check("blk_next_psel",   32'(psel),      32'd0);

    // ---- Reset during SETUP of a read ----
    tick();
    hwrite = 1'b0;
    htrans = 2'b10;
    haddr  = 32'h8000_0040;
    tick();
    drive_idle();
    sample();
    check("rst_setup_psel", 32'(psel), 32'b001);
    hreset = 1'b1;
    tick();
    sample();
    check("rst_mid_psel",    32'(psel),      32'd0);
    check("rst_mid_penable", 32'(penable),   32'd0);
    check("rst_mid_hready",  32'(hreadyout), 32'd1);
    check("rst_mid_paddr",   paddr,          32'h0);
    hreset = 1'b0;

`ifdef BRIDGE_PREADY_EN
    // ---- pready held low for 3 ACCESS cycles ----
    tick();
    hwrite = 1'b0;
    htrans = 2'b10;
    haddr  = 32'h8000_0100;
    sb.push_back(mk_exp(32'h8000_0100, 1'b0, periph_data(32'h8000_0100)));
    tick();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      pready = 1'b0;
      sample();
      check("stall_penable", 32'(penable),   32'd1);
      check("stall_hready",  32'(hreadyout), 32'd0);
      check("stall_paddr",   paddr,          32'h8000_0100);
      check("stall_psel",    32'(psel),      32'b001);
    end
    tick();
    pready = 1'b1;
    sample();
    check("stall_end_penable", 32'(penable),   32'd1);
    check("stall_end_hready",  32'(hreadyout), 32'd1);
    tick();
    sample();
    check("stall_idle_penable", 32'(penable), 32'd0);
`endif

    tick();
    sample();
    check("sb_empty_final", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
